// File: rtl/clip_scheduler.sv
// Audio clip scheduler: arbitrates count/color requests into a clip FIFO and
// sequences one clip at a time through a shared sample player.
module clip_scheduler #(
    parameter int QDEPTH    = 4,
    parameter int COUNT_MAX = 9
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      redCountAudioRequest,
    input  logic                      greenCountAudioRequest,
    input  logic                      redAudioRequest,
    input  logic                      greenAudioRequest,
    input  logic                      sampleDoneAck,
    input  logic                      playerDone,
    output logic                      playStart,
    output logic [4:0]                clipSel,
    output logic                      sampleDone,
    output logic                      busy,
    output logic [$clog2(QDEPTH):0]   queueLevel,
    output logic                      dropped,
    output logic [3:0]                redCount,
    output logic [3:0]                greenCount
);

    localparam int PW = $clog2(QDEPTH);
    localparam int LW = PW + 1;
    localparam logic [4:0] CLIP_RED   = 5'd16;
    localparam logic [4:0] CLIP_GREEN = 5'd17;

    typedef enum logic [1:0] {IDLE, START, PLAY, DONE} state_t;

    state_t        state;
    logic [4:0]    mem [QDEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic          req_any;
    logic          req_multi;
    logic [4:0]    push_val;
    logic          pop;
    logic          full;
    logic          push;
    logic [3:0]    red_next;
    logic [3:0]    green_next;

    assign red_next   = (redCount   == 4'(COUNT_MAX)) ? '0 : redCount   + 4'd1;
    assign green_next = (greenCount == 4'(COUNT_MAX)) ? '0 : greenCount + 4'd1;

    assign req_any   = redCountAudioRequest | greenCountAudioRequest |
                       redAudioRequest | greenAudioRequest;
    assign req_multi = (32'(redCountAudioRequest) + 32'(greenCountAudioRequest) +
                        32'(redAudioRequest) + 32'(greenAudioRequest)) > 32'd1;

    always_comb begin
        push_val = '0;
        if (redCountAudioRequest)
            push_val = {1'b0, red_next};
        else if (greenCountAudioRequest)
            push_val = {1'b0, green_next};
        else if (redAudioRequest)
            push_val = CLIP_RED;
        else if (greenAudioRequest)
            push_val = CLIP_GREEN;
    end

    // A full queue still accepts when the head leaves in the same cycle.
    assign pop  = (state == START);
    assign full = (queueLevel == LW'(QDEPTH));
    assign push = req_any && (!full || pop);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_val;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            queueLevel <= '0;
            dropped    <= 1'b0;
            redCount   <= '0;
            greenCount <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (redCountAudioRequest)
                    redCount <= red_next;
                else if (!redCountAudioRequest && greenCountAudioRequest)
                    greenCount <= green_next;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                queueLevel <= queueLevel + 1'b1;
            else if (pop && !push)
                queueLevel <= queueLevel - 1'b1;
            if (req_multi || (req_any && !push))
                dropped <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            playStart  <= 1'b0;
            clipSel    <= '0;
            sampleDone <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (queueLevel != '0) begin
                        state     <= START;
                        playStart <= 1'b1;
                        clipSel   <= mem[rd_ptr];
                        busy      <= 1'b1;
                    end
                end
                START: begin
                    state     <= PLAY;
                    playStart <= 1'b0;
                end
                PLAY: begin
                    if (playerDone) begin
                        state      <= DONE;
                        sampleDone <= 1'b1;
                    end
                end
                DONE: begin
                    if (sampleDoneAck) begin
                        state      <= IDLE;
                        sampleDone <= 1'b0;
                        busy       <= 1'b0;
                        clipSel    <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clip_scheduler.sv
// Directed bench for clip_scheduler: inputs change and outputs are sampled on
// the falling edge, so each step() is one rising edge of the design clock.
module tb_clip_scheduler;

    logic       clk;
    logic       reset;
    logic       redCountAudioRequest;
    logic       greenCountAudioRequest;
    logic       redAudioRequest;
    logic       greenAudioRequest;
    logic       sampleDoneAck;
    logic       playerDone;
    logic       playStart;
    logic [4:0] clipSel;
    logic       sampleDone;
    logic       busy;
    logic [2:0] queueLevel;
    logic       dropped;
    logic [3:0] redCount;
    logic [3:0] greenCount;

    int checks = 0;
    int errors = 0;

    clip_scheduler #(.QDEPTH(4), .COUNT_MAX(9)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .redCountAudioRequest   (redCountAudioRequest),
        .greenCountAudioRequest (greenCountAudioRequest),
        .redAudioRequest        (redAudioRequest),
        .greenAudioRequest      (greenAudioRequest),
        .sampleDoneAck          (sampleDoneAck),
        .playerDone             (playerDone),
        .playStart              (playStart),
        .clipSel                (clipSel),
        .sampleDone             (sampleDone),
        .busy                   (busy),
        .queueLevel             (queueLevel),
        .dropped                (dropped),
        .redCount               (redCount),
        .greenCount             (greenCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_playStart"},  32'(playStart),  0);
        check({tag, "_clipSel"},    32'(clipSel),    0);
        check({tag, "_sampleDone"}, 32'(sampleDone), 0);
        check({tag, "_busy"},       32'(busy),       0);
        check({tag, "_queueLevel"}, 32'(queueLevel), 0);
        check({tag, "_dropped"},    32'(dropped),    0);
        check({tag, "_redCount"},   32'(redCount),   0);
        check({tag, "_greenCount"}, 32'(greenCount), 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        check_all_zero("reset");
        reset = 1'b1;
        step();
    endtask

    // From PLAY: pulse playerDone, confirm sampleDone, then acknowledge.
    task automatic finish_clip(input string tag);
        playerDone = 1'b1;
        step();
        playerDone = 1'b0;
        check({tag, "_sampleDone"}, 32'(sampleDone), 1);
        sampleDoneAck = 1'b1;
        step();
        sampleDoneAck = 1'b0;
        check({tag, "_ackCleared"}, 32'(sampleDone), 0);
    endtask

    initial begin
        reset                  = 1'b0;
        redCountAudioRequest   = 1'b0;
        greenCountAudioRequest = 1'b0;
        redAudioRequest        = 1'b0;
        greenAudioRequest      = 1'b0;
        sampleDoneAck          = 1'b0;
        playerDone             = 1'b0;
        step();
        do_reset();

        // Single red count with full handshake.
        redCountAudioRequest = 1'b1;
        step();
        redCountAudioRequest = 1'b0;
        check("single_playStart_early", 32'(playStart),  0);
        check("single_redCount",        32'(redCount),   1);
        check("single_level",           32'(queueLevel), 1);
        step();
        check("single_playStart",       32'(playStart),  1);
        check("single_clipSel",         32'(clipSel),    1);
        check("single_busy",            32'(busy),       1);
        step();
        check("single_playStart_pulse", 32'(playStart),  0);
        check("single_clipSel_hold",    32'(clipSel),    1);
        check("single_level_popped",    32'(queueLevel), 0);
        playerDone = 1'b1;
        step();
        playerDone = 1'b0;
        check("single_sampleDone",      32'(sampleDone), 1);
        step();
        step();
        check("single_sampleDone_held", 32'(sampleDone), 1);
        sampleDoneAck = 1'b1;
        step();
        sampleDoneAck = 1'b0;
        check("single_sampleDone_clr",  32'(sampleDone), 0);
        check("single_busy_idle",       32'(busy),       0);
        check("single_clipSel_idle",    32'(clipSel),    0);
        playerDone = 1'b1;
        step();
        playerDone = 1'b0;
        check("single_ignore_done",     32'(sampleDone), 0);

        // Announcement: count clip then color word, in order.
        do_reset();
        redCountAudioRequest = 1'b1;
        step();
        redCountAudioRequest = 1'b0;
        step();
        check("ann_first_start", 32'(playStart), 1);
        check("ann_first_clip",  32'(clipSel),   1);
        step();
        redAudioRequest = 1'b1;
        step();
        redAudioRequest = 1'b0;
        check("ann_queued",      32'(queueLevel), 1);
        finish_clip("ann_first");
        check("ann_no_start_yet", 32'(playStart), 0);
        step();
        check("ann_second_start", 32'(playStart), 1);
        check("ann_second_clip",  32'(clipSel),   16);
        check("ann_counts",       32'(redCount),  1);

        // Green count wraps after COUNT_MAX.
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            greenCountAudioRequest = 1'b1;
            step();
            greenCountAudioRequest = 1'b0;
            check($sformatf("wrap_count_%0d", i), 32'(greenCount), 32'(i % 10));
            step();
            check($sformatf("wrap_start_%0d", i), 32'(playStart), 1);
            check($sformatf("wrap_clip_%0d", i),  32'(clipSel),   32'(i % 10));
            step();
            finish_clip($sformatf("wrap_%0d", i));
        end
        check("wrap_dropped", 32'(dropped), 0);

        // Overflow with a stalled player: one playing, four queued, one lost.
        do_reset();
        redCountAudioRequest = 1'b1;
        for (int i = 0; i < 6; i++) step();
        redCountAudioRequest = 1'b0;
        check("ovf_level",    32'(queueLevel), 4);
        check("ovf_dropped",  32'(dropped),    1);
        check("ovf_redCount", 32'(redCount),   5);
        check("ovf_playing",  32'(clipSel),    1);
        check("ovf_busy",     32'(busy),       1);
        for (int k = 2; k <= 5; k++) begin
            finish_clip($sformatf("ovf_clip_%0d", k - 1));
            step();
            check($sformatf("ovf_start_%0d", k), 32'(playStart), 1);
            check($sformatf("ovf_order_%0d", k), 32'(clipSel),   32'(k));
            step();
        end
        check("ovf_drained",        32'(queueLevel), 0);
        check("ovf_dropped_sticky", 32'(dropped),    1);

        // Simultaneous pulses: only the higher priority request survives.
        do_reset();
        redCountAudioRequest = 1'b1;
        greenAudioRequest    = 1'b1;
        step();
        redCountAudioRequest = 1'b0;
        greenAudioRequest    = 1'b0;
        check("sim_level",      32'(queueLevel), 1);
        check("sim_dropped",    32'(dropped),    1);
        check("sim_greenCount", 32'(greenCount), 0);
        check("sim_redCount",   32'(redCount),   1);
        step();
        check("sim_clip",       32'(clipSel),    1);
        step();
        check("sim_only_one",   32'(queueLevel), 0);

        // Reset asserted mid-PLAY abandons the clip.
        do_reset();
        greenAudioRequest = 1'b1;
        step();
        greenAudioRequest = 1'b0;
        step();
        step();
        check("rst_play_busy", 32'(busy),    1);
        check("rst_play_clip", 32'(clipSel), 17);
        reset = 1'b0;
        #1;
        check_all_zero("rst_async");
        step();
        reset = 1'b1;
        step();
        playerDone = 1'b1;
        step();
        playerDone = 1'b0;
        check("rst_no_sampleDone", 32'(sampleDone), 0);
        check("rst_idle_busy",     32'(busy),       0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
